// File: rtl/alu_op_issuer_if.sv
// Command, datapath and result signal bundle for alu_op_issuer.
// The master modport is the issuer's view; slave is the environment's view.
interface alu_op_issuer_if #(parameter int DATA_W = 32);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [2:0]        cmd_op;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_x;
  logic              alu_z;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_x;
  logic              res_z;
  logic [2:0]        res_op;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_x, alu_z, res_ready,
    output cmd_ready, alu_a, alu_b, alu_op, res_valid, res_x, res_z, res_op
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_x, alu_z, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_op, res_valid, res_x, res_z, res_op
  );
endinterface

// File: rtl/alu_op_issuer.sv
// Issues ops to a fixed-latency ALU datapath, captures X/Z into a FWFT result FIFO
// and credit-gates acceptance so a launched op always has a FIFO slot waiting.
module alu_op_issuer #(
  parameter int DATA_W      = 32,
  parameter int ALU_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                resetn,
  alu_op_issuer_if.master     bus,
  output logic                err_illegal_op,
  output logic [CNT_W-1:0]    zero_count,
  input  logic                zero_count_clr,
  output logic                busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = DATA_W + 4;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  typedef struct packed {
    logic       vld;
    logic [2:0] op;
  } slot_t;

  slot_t [ALU_LATENCY:0] r_pipe;
  logic  [EW-1:0]        r_mem [FIFO_DEPTH];
  logic  [PW-1:0]        r_wptr, r_rptr;
  logic  [CW-1:0]        r_cnt;
  logic                  r_cmd_ready;
  logic                  r_err;
  logic  [CNT_W-1:0]     r_zcnt;
  logic  [DATA_W-1:0]    r_alu_a, r_alu_b;
  logic  [2:0]           r_alu_op;

  logic                  w_accept, w_launch, w_push, w_pop, w_full;
  logic  [CW-1:0]        w_infl, w_infl_nxt, w_cnt_nxt;
  logic  [CW:0]          w_total_nxt;
  logic  [EW-1:0]        w_head;

  assign w_accept = bus.cmd_valid && r_cmd_ready;
  assign w_launch = w_accept && (bus.cmd_op != OP_ILLEGAL);
  assign w_push   = r_pipe[ALU_LATENCY].vld;
  assign w_pop    = (r_cnt != '0) && bus.res_ready;
  assign w_full   = (r_cnt == CW'(FIFO_DEPTH));

  // Credit is judged on post-edge occupancy so the registered ready is exact.
  always_comb begin
    w_infl     = '0;
    w_infl_nxt = {{(CW-1){1'b0}}, w_launch};
    for (int i = 0; i <= ALU_LATENCY; i++)
      w_infl = w_infl + {{(CW-1){1'b0}}, r_pipe[i].vld};
    for (int i = 0; i < ALU_LATENCY; i++)
      w_infl_nxt = w_infl_nxt + {{(CW-1){1'b0}}, r_pipe[i].vld};
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop)
      w_cnt_nxt = r_cnt + CW'(1);
    else if (!w_push && w_pop)
      w_cnt_nxt = r_cnt - CW'(1);
    w_total_nxt = {1'b0, w_infl_nxt} + {1'b0, w_cnt_nxt};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pipe      <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b0;
      r_err       <= 1'b0;
      r_zcnt      <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= 3'b000;
    end else begin
      r_pipe[0] <= '{vld: w_launch, op: bus.cmd_op};
      for (int i = 1; i <= ALU_LATENCY; i++)
        r_pipe[i] <= r_pipe[i-1];
      if (w_launch) begin
        r_alu_a  <= bus.cmd_a;
        r_alu_b  <= bus.cmd_b;
        r_alu_op <= bus.cmd_op;
      end
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_cnt       <= w_cnt_nxt;
      r_cmd_ready <= (w_total_nxt < (CW+1)'(FIFO_DEPTH));
      r_err       <= w_accept && (bus.cmd_op == OP_ILLEGAL);
      if (zero_count_clr)
        r_zcnt <= '0;
      else if (w_push && bus.alu_z && !(&r_zcnt))
        r_zcnt <= r_zcnt + CNT_W'(1);
    end
  end

  // Storage is not reset; the read side is masked while empty.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= {r_pipe[ALU_LATENCY].op, bus.alu_z, bus.alu_x};
  end

  assign w_head        = r_mem[r_rptr];
  assign bus.res_valid = (r_cnt != '0);
  assign bus.res_x     = bus.res_valid ? w_head[DATA_W-1:0] : '0;
  assign bus.res_z     = bus.res_valid ? w_head[DATA_W]     : 1'b0;
  assign bus.res_op    = bus.res_valid ? w_head[EW-1:DATA_W+1] : 3'b000;
  assign bus.cmd_ready = r_cmd_ready;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_op    = r_alu_op;
  assign err_illegal_op = r_err;
  assign zero_count     = r_zcnt;
  assign busy           = (w_infl != '0) || (r_cnt != '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn) !(w_push && w_full));
endmodule
